// File: rtl/uba_bus_arb_if.sv
// ---------------------------------------------------------------------------
// uba_bus_arb_if
//   Handshake bundle between the UBA internal requesters, the bus arbiter and
//   the KS10 backplane bus interface.
//
//   Signals:
//     req     [NREQ]  per-requester bus request (level)
//     gnt     [NREQ]  one-hot grant, keys the external address/data mux
//     done    [NREQ]  one-cycle completion pulse to the granted requester
//     tmo     [NREQ]  one-cycle timeout pulse to the granted requester
//     busREQO         KS10 bus request
//     busACKI         KS10 bus acknowledge
//     setTMO          one-cycle pulse that sets the UBA TMO status bit
//
//   Modports:
//     master  the arbiter: drives grants, pulses and busREQO
//     slave   requesters + bus side: drive req and busACKI
// ---------------------------------------------------------------------------
interface uba_bus_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] tmo;
  logic            busREQO;
  logic            busACKI;
  logic            setTMO;

  modport master (
    input  req,
    input  busACKI,
    output gnt,
    output done,
    output tmo,
    output busREQO,
    output setTMO
  );

  modport slave (
    output req,
    output busACKI,
    input  gnt,
    input  done,
    input  tmo,
    input  busREQO,
    input  setTMO
  );
endinterface

// File: rtl/uba_bus_arb.sv
// ---------------------------------------------------------------------------
// uba_bus_arb
//   Round-robin arbiter and transaction sequencer for the UBA's single KS10
//   bus master port. A winner is granted from IDLE, busREQO is held until
//   busACKI or until TIMEOUT cycles elapse, and one turnaround cycle follows
//   every transaction.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   uba_bus_arb_if.master (req, busACKI in; gnt, done, tmo,
//           busREQO, setTMO out -- all outputs registered)
//
//   Parameters:
//     NREQ     number of requesters (2..8)
//     TIMEOUT  max busREQO cycles without busACKI (1..15)
//     CW       timeout counter width, 2**CW > TIMEOUT
// ---------------------------------------------------------------------------
module uba_bus_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 12,
  parameter int CW      = 4
) (
  input  logic           clk,
  input  logic           rst,
  uba_bus_arb_if.master  bus
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   rr;       // index of the most recently granted requester

  logic [RW-1:0]   win_idx;
  logic            win_vld;
  int              idx;

  // Round-robin pick: scan rr+1, rr+2, ... (mod NREQ) and keep the first
  // set request bit, so the last winner is considered only after everyone else.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    win_idx = rr;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr) + k) % NREQ;
      if (!win_vld && bus.req[idx]) begin
        win_idx = RW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rr          <= RW'(NREQ - 1);
      bus.gnt     <= '0;
      bus.done    <= '0;
      bus.tmo     <= '0;
      bus.busREQO <= 1'b0;
      bus.setTMO  <= 1'b0;
    end else begin
      // Completion pulses are one cycle wide unless re-asserted below.
      bus.done   <= '0;
      bus.tmo    <= '0;
      bus.setTMO <= 1'b0;

      case (state)
        IDLE: begin
          if (win_vld) begin
            bus.gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            bus.busREQO <= 1'b1;
            cnt         <= CW'(TIMEOUT);
            rr          <= win_idx;
            state       <= REQ;
          end
        end

        REQ: begin
          // gnt is one-hot on rr here, so it doubles as the pulse vector.
          // The ack test comes first: an ack on the last allowed cycle wins.
          if (bus.busACKI) begin
            bus.done    <= bus.gnt;
            bus.gnt     <= '0;
            bus.busREQO <= 1'b0;
            cnt         <= '0;
            state       <= TURN;
          end else if (cnt == CW'(1)) begin
            bus.tmo     <= bus.gnt;
            bus.setTMO  <= 1'b1;
            bus.gnt     <= '0;
            bus.busREQO <= 1'b0;
            cnt         <= '0;
            state       <= TURN;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        TURN: begin
          // Bus turnaround: outputs already low, stray acks ignored.
          bus.gnt     <= '0;
          bus.busREQO <= 1'b0;
          cnt         <= '0;
          state       <= IDLE;
        end

        default: begin
          bus.gnt     <= '0;
          bus.busREQO <= 1'b0;
          cnt         <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uba_bus_arb.sv
// ---------------------------------------------------------------------------
// tb_uba_bus_arb
//   Self-checking bench for uba_bus_arb (NREQ=4, TIMEOUT=12, CW=4): a vector
//   table, hand-written multi-cycle sequences, and a randomized run against a
//   transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_uba_bus_arb;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 12;
  localparam int CW      = 4;

  logic clk;
  logic rst;

  uba_bus_arb_if #(.NREQ(NREQ)) bus_if ();

  uba_bus_arb #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 ns after the edge.
  task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic a);
    rst            = r;
    bus_if.req     = rq;
    bus_if.busACKI = a;
    @(posedge clk);
    #1;
  endtask

  // {gnt, done, tmo, busREQO, setTMO}
  function automatic logic [3*NREQ+1:0] outs();
    return {bus_if.gnt, bus_if.done, bus_if.tmo, bus_if.busREQO, bus_if.setTMO};
  endfunction

  // Hold req at rq with no ack and count how many cycles busREQO is seen high.
  task automatic count_hold(input logic [NREQ-1:0] rq, output int hi);
    hi = 0;
    for (int n = 0; n < 20; n++) begin
      if (!bus_if.busREQO) break;
      hi++;
      step(1'b0, rq, 1'b0);
    end
  endtask

  // ------------------------------------------------------------------
  // Vector table
  // ------------------------------------------------------------------
  typedef struct {
    logic            r;
    logic [NREQ-1:0] rq;
    logic            a;
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_done;
    logic [NREQ-1:0] e_tmo;
    logic            e_breq;
    logic            e_set;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [NREQ-1:0] rq, input logic a,
                     input logic [NREQ-1:0] g, input logic [NREQ-1:0] d,
                     input logic [NREQ-1:0] t, input logic b, input logic s);
    vec_t v;
    v.r = r; v.rq = rq; v.a = a;
    v.e_gnt = g; v.e_done = d; v.e_tmo = t; v.e_breq = b; v.e_set = s;
    vecs.push_back(v);
  endtask

  // ------------------------------------------------------------------
  // Reference model: tracks who owns the bus, how long it has held it,
  // remaining turnaround, and the last winner.
  // ------------------------------------------------------------------
  int              m_owner;
  int              m_held;
  int              m_cool;
  int              m_last;
  logic [NREQ-1:0] e_gnt, e_done, e_tmo;
  logic            e_breq, e_set;

  task automatic model_step(input logic r, input logic [NREQ-1:0] rq, input logic a);
    e_done = '0;
    e_tmo  = '0;
    e_set  = 1'b0;
    if (r) begin
      m_owner = -1; m_held = 0; m_cool = 0; m_last = NREQ - 1;
    end else if (m_owner >= 0) begin
      if (a) begin
        e_done[m_owner] = 1'b1;
        m_owner = -1; m_cool = 1;
      end else if (m_held == TIMEOUT) begin
        e_tmo[m_owner] = 1'b1;
        e_set = 1'b1;
        m_owner = -1; m_cool = 1;
      end else begin
        m_held++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (rq != '0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (rq[c]) begin
          m_owner = c; m_last = c; m_held = 1;
          break;
        end
      end
    end
    e_gnt  = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    e_breq = (m_owner >= 0);
  endtask

  int hi;

  initial begin
    rst = 1'b1;
    bus_if.req = '0;
    bus_if.busACKI = 1'b0;
    @(posedge clk);
    #1;

    // ---------------- table: single request, then fairness ----------------
    add(1, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0); // reset state
    add(0, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 1, 0); // REQ cycle 1
    add(0, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 1, 0); // REQ cycle 2
    add(0, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 1, 0); // REQ cycle 3
    add(0, 4'b0001, 1, 4'b0000, 4'b0001, 4'b0000, 0, 0); // ack -> done (TURN)
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0); // IDLE
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0); // IDLE
    add(1, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0); // reset, rr=NREQ-1
    for (int i = 0; i < 5; i++) begin
      logic [NREQ-1:0] oh;
      oh = NREQ'(1) << (i % NREQ);
      add(0, 4'b1111, 1, oh,      4'b0000, 4'b0000, 1, 0);
      add(0, 4'b1111, 1, 4'b0000, oh,      4'b0000, 0, 0);
      add(0, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].rq, vecs[i].a);
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].e_gnt, vecs[i].e_done, vecs[i].e_tmo, vecs[i].e_breq, vecs[i].e_set}));
    end

    // ---------------- timeout ----------------
    step(1, 4'b0000, 0);
    step(0, 4'b0100, 0);
    check("tmo_gnt", 32'(bus_if.gnt), 32'(4'b0100));
    count_hold(4'b0100, hi);
    check("tmo_hold_cycles", hi, TIMEOUT);
    check("tmo_pulse", 32'({bus_if.tmo, bus_if.setTMO, bus_if.done}), 32'({4'b0100, 1'b1, 4'b0000}));
    step(0, 4'b0000, 0);
    check("tmo_one_cycle", 32'({bus_if.tmo, bus_if.setTMO}), 32'(0));

    // ---------------- ack / timeout collision ----------------
    step(1, 4'b0000, 0);
    step(0, 4'b0001, 0);                         // REQ cycle 1 visible
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 4'b0001, 0);
    check("coll_breq_last", 32'(bus_if.busREQO), 32'(1));
    step(0, 4'b0001, 1);                         // ack on the TIMEOUT-th cycle
    check("coll_result", 32'({bus_if.done, bus_if.tmo, bus_if.setTMO}), 32'({4'b0001, 4'b0000, 1'b0}));

    // ---------------- reset mid-transaction ----------------
    step(1, 4'b0000, 0);
    step(0, 4'b0001, 0);
    for (int i = 0; i < 4; i++) step(0, 4'b0001, 0); // REQ cycle 5 visible
    step(1, 4'b0001, 0);
    check("rst_mid_outs", 32'(outs()), 32'(0));
    step(0, 4'b0010, 0);
    check("rst_regrant", 32'(bus_if.gnt), 32'(4'b0010));
    count_hold(4'b0010, hi);
    check("rst_cnt_full", hi, TIMEOUT);
    check("rst_tmo", 32'(bus_if.tmo), 32'(4'b0010));

    // ---------------- stray ack, dropped req ----------------
    step(1, 4'b0000, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b0000, 1);
      check($sformatf("stray_ack%0d", i), 32'(outs()), 32'(0));
    end
    step(0, 4'b0100, 0);
    check("drop_gnt", 32'(bus_if.gnt), 32'(4'b0100));
    step(0, 4'b0000, 0);                         // requester drops req
    count_hold(4'b0000, hi);
    check("drop_hold", hi, TIMEOUT - 1);
    check("drop_tmo", 32'({bus_if.tmo, bus_if.setTMO}), 32'({4'b0100, 1'b1}));

    // ---------------- randomized run vs model ----------------
    step(1, 4'b0000, 0);
    model_step(1, 4'b0000, 0);
    for (int blk = 0; blk < 6; blk++) begin
      int ack_pct;
      case (blk)
        0: ack_pct = 40;
        1: ack_pct = 5;
        2: ack_pct = 0;
        3: ack_pct = 70;
        4: ack_pct = 10;
        default: ack_pct = 25;
      endcase
      for (int n = 0; n < 500; n++) begin
        logic            r, a;
        logic [NREQ-1:0] rq;
        r  = ($urandom_range(0, 299) == 0);
        rq = NREQ'($urandom_range(0, (1 << NREQ) - 1));
        a  = ($urandom_range(0, 99) < ack_pct);
        model_step(r, rq, a);
        step(r, rq, a);
        check("rand_outs", 32'(outs()), 32'({e_gnt, e_done, e_tmo, e_breq, e_set}));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
